obf_seq: RTL

- Obfuscation sequencer sitting directly upstream of obf_lut, between the decode-side instruction source and the execute-side consumer.
- For each accepted instruction it walks substitution indices 0,1,2… on lut_addr = {igu, sub}.
- For every step it assembles one output instruction from the LUT entry and the original operands, and stops at the entry whose last bit is set.
- It back-pressures the upstream source while a multi-instruction substitution is being emitted.

---
 rtl/obf_seq_pkg.sv | 49 ++++
 rtl/obf_seq_if.sv | 28 ++
 rtl/obf_insn_asm.sv | 34 +++
 rtl/obf_seq.sv | 84 ++++++++
 4 files changed

// File: rtl/obf_seq_pkg.sv
// Shared widths, LUT entry layout and instruction constants for the obfuscation sequencer.
package obf_seq_pkg;

  localparam int IGU_W     = 7;
  localparam int SUB_W     = 3;
  localparam int TYPE_W    = 2;
  localparam int TPL_W     = 16;
  localparam int LUT_OUT_W = TYPE_W + TPL_W + 1;
  localparam int ADDR_W    = IGU_W + SUB_W;
  localparam int INSN_W    = 32;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_N = 2'd0,
    TYPE_A = 2'd1,
    TYPE_S = 2'd2,
    TYPE_R = 2'd3
  } insn_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // LUT word layout, MSB first: {type, template, last}
  typedef struct packed {
    logic [TYPE_W-1:0] itype;
    logic [TPL_W-1:0]  tpl;
    logic              last;
  } lut_entry_t;

  localparam logic [5:0]        OPC_ALU = 6'h38;
  localparam logic [INSN_W-1:0] OBF_NOP = 32'h1500_0000;

  // Template bit positions: register-field masks and the ALU function byte
  localparam int TPL_MASK_D  = 7;
  localparam int TPL_MASK_A  = 6;
  localparam int TPL_MASK_B  = 5;
  localparam int TPL_FUNC_LO = 8;
  localparam int TPL_FUNC_HI = 15;

  function automatic lut_entry_t passthru_entry();
    lut_entry_t e;
    e.itype = TYPE_N;
    e.tpl   = '0;
    e.last  = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/obf_seq_if.sv
// Upstream accept and downstream emit handshakes of the obfuscation sequencer.
interface obf_seq_if;
  import obf_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [INSN_W-1:0] in_insn;
  logic [IGU_W-1:0]  in_igu;

  logic              out_valid;
  logic              out_ready;
  logic [INSN_W-1:0] out_insn;
  logic              out_last;
  logic [SUB_W-1:0]  out_sub;

  // slave: the sequencer itself
  modport slave (
    input  in_valid, in_insn, in_igu, out_ready,
    output in_ready, out_valid, out_insn, out_last, out_sub
  );

  // master: instruction source plus execute-side sink
  modport master (
    output in_valid, in_insn, in_igu, out_ready,
    input  in_ready, out_valid, out_insn, out_last, out_sub
  );

endinterface

// File: rtl/obf_insn_asm.sv
// Combinational assembly of one emitted instruction from a LUT entry and the held original.
module obf_insn_asm
  import obf_seq_pkg::*;
(
  input  insn_type_e        itype,
  input  logic [TPL_W-1:0]  tpl,
  input  logic [INSN_W-1:0] insn,
  output logic [INSN_W-1:0] out_insn
);

  logic [14:0]       reg_fields;
  logic [INSN_W-1:0] alu_insn;
  logic              unused_tpl;

  // D, A, B register fields sit at 25:21, 20:16, 15:11; each has its own zeroing mask bit
  for (genvar gi = 0; gi < 3; gi++) begin : g_field
    localparam int FIELD_LSB = 21 - 5 * gi;
    localparam int MASK_BIT  = TPL_MASK_D - gi;
    assign reg_fields[14 - 5 * gi -: 5] = tpl[MASK_BIT] ? 5'd0 : insn[FIELD_LSB +: 5];
  end

  assign alu_insn   = {OPC_ALU, reg_fields, 3'b000, tpl[TPL_FUNC_HI:TPL_FUNC_LO]};
  assign unused_tpl = ^tpl[4:0];

  always_comb begin
    out_insn = insn;
    case (itype)
      TYPE_A:  out_insn = alu_insn;
      TYPE_S:  out_insn = OBF_NOP;
      default: out_insn = insn;
    endcase
  end

endmodule

// File: rtl/obf_seq.sv
// Obfuscation sequencer: walks LUT substitution indices per accepted instruction and emits
// one assembled instruction per step, back-pressuring upstream until the last step.
module obf_seq
  import obf_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 obf_en,
  obf_seq_if.slave             bus,
  output logic [ADDR_W-1:0]    lut_addr,
  input  logic [LUT_OUT_W-1:0] lut_out
);

  state_e            state_reg;
  logic [SUB_W-1:0]  sub_reg;
  logic [INSN_W-1:0] insn_reg;
  logic [IGU_W-1:0]  igu_reg;
  logic              en_reg;

  lut_entry_t        lut_entry;
  lut_entry_t        entry;
  logic              emitting;
  logic              eff_last;
  logic              step;
  logic              accept;
  logic [SUB_W-1:0]  sub_next;
  logic [INSN_W-1:0] asm_insn;

  assign lut_addr  = {igu_reg, sub_reg};
  assign lut_entry = lut_out;

  // With obfuscation disabled at accept, the LUT is ignored and the original passes once
  assign entry    = en_reg ? lut_entry : passthru_entry();
  // The index saturates: the final index always terminates the walk
  assign eff_last = entry.last | (&sub_reg);
  assign sub_next = sub_reg + SUB_W'(1);

  assign emitting = (state_reg == ST_EMIT);
  assign step     = emitting & bus.out_ready;

  // Ready while idle, or in the very cycle the last step leaves, for back-to-back accepts
  assign bus.in_ready = ~flush & (~emitting | (step & eff_last));
  assign accept       = bus.in_valid & bus.in_ready;

  obf_insn_asm u_asm (
    .itype    (insn_type_e'(entry.itype)),
    .tpl      (entry.tpl),
    .insn     (insn_reg),
    .out_insn (asm_insn)
  );

  assign bus.out_valid = emitting;
  assign bus.out_insn  = emitting ? asm_insn : '0;
  assign bus.out_last  = emitting & eff_last;
  assign bus.out_sub   = sub_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      sub_reg   <= '0;
      insn_reg  <= '0;
      igu_reg   <= '0;
      en_reg    <= 1'b0;
    end else if (flush) begin
      state_reg <= ST_IDLE;
      sub_reg   <= '0;
    end else if (accept) begin
      state_reg <= ST_EMIT;
      sub_reg   <= '0;
      insn_reg  <= bus.in_insn;
      igu_reg   <= bus.in_igu;
      en_reg    <= obf_en;
    end else if (step) begin
      if (eff_last) begin
        state_reg <= ST_IDLE;
        sub_reg   <= '0;
      end else begin
        sub_reg   <= sub_next;
      end
    end
  end

endmodule
